// File: rtl/cordic_cos_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_cos_iter: float angle in, iterative CORDIC cos/sin/residual out      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module cordic_cos_iter #(
    parameter int W    = 32,
    parameter int FRAC = 30,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_angle,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin,
    output logic [W-1:0] out_theta,
    output logic         out_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_rot  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Elaboration-time constants are built with 62-bit (atan) and 60-bit (gain)
    // integer precision, then rounded once down to FRAC bits.
    function automatic logic [63:0] atan_inv_q62(input logic [63:0] n);
        logic [63:0] p;
        logic [63:0] sum;
        sum = '0;
        p   = (64'd1 << 62) / n;
        for (int k = 0; k < 48; k++) begin
            if (k[0])
                sum = sum - p / 64'(2 * k + 1);
            else
                sum = sum + p / 64'(2 * k + 1);
            p = p / (n * n);
        end
        return sum;
    endfunction

    function automatic logic [63:0] atan_q62(input int i);
        if (i == 0)
            return 64'd4 * atan_inv_q62(64'd5) - atan_inv_q62(64'd239);
        return atan_inv_q62(64'd1 << i);
    endfunction

    function automatic logic [W-1:0] round_q62(input logic [63:0] v);
        logic [63:0] r;
        r = (v + (64'd1 << (61 - FRAC))) >> (62 - FRAC);
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] kinv_fix(input int n_iter);
        logic [255:0] p;
        logic [255:0] q;
        logic [255:0] root;
        logic [255:0] bitv;
        p = 256'd1 << 60;
        for (int i = 0; i < n_iter; i++)
            p = p + (p >> (2 * i));
        q    = (256'd1 << 180) / p;
        root = '0;
        for (int b = 127; b >= 0; b--) begin
            bitv = 256'd1 << (2 * b);
            if (q >= root + bitv) begin
                q    = q - (root + bitv);
                root = (root >> 1) + bitv;
            end else begin
                root = root >> 1;
            end
        end
        root = (root + (256'd1 << (59 - FRAC))) >> (60 - FRAC);
        return root[W-1:0];
    endfunction

    localparam logic [W-1:0] c_kinv      = kinv_fix(ITER);
    localparam logic [W-1:0] c_half_pi   = round_q62(64'd2 * atan_q62(0));
    localparam logic [4:0]   c_last_iter = 5'(ITER - 1);

    logic [W-1:0] w_atan_tab [0:30];

    for (genvar gi = 0; gi < 31; gi++) begin : g_atan
        localparam logic [W-1:0] c_atan = round_q62(atan_q62(gi));
        assign w_atan_tab[gi] = c_atan;
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [31:0]         r_angle;
    logic [4:0]          r_iter;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_z;
    logic [W-1:0]        r_cos;
    logic [W-1:0]        r_sin;
    logic [W-1:0]        r_theta;
    logic                r_err;

    // Float to fixed conversion of the latched angle.
    logic [7:0]   w_exp;
    logic [9:0]   w_shift;
    logic [W-1:0] w_mant_ext;
    logic [W-1:0] w_mag;
    logic [W-1:0] w_z0;
    logic         w_conv_err;

    always_comb begin
        w_exp      = r_angle[30:23];
        w_mant_ext = {{(W - 24){1'b0}}, 1'b1, r_angle[22:0]};
        w_shift    = {2'b00, w_exp} - 10'(150 - FRAC);
        w_mag      = '0;
        // exp >= 128 means |angle| >= 2, always out of range, so the shift never overflows.
        if (w_exp != 8'd0 && !w_exp[7]) begin
            if (!w_shift[9])
                w_mag = w_mant_ext << w_shift;
            else
                w_mag = w_mant_ext >> (-w_shift);
        end
        w_conv_err = w_exp[7] || (w_mag > c_half_pi);
        w_z0       = r_angle[31] ? -w_mag : w_mag;
    end

    logic signed [W-1:0] w_atan;
    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;
    logic signed [W-1:0] w_x_next;
    logic signed [W-1:0] w_y_next;
    logic signed [W-1:0] w_z_next;

    always_comb begin
        w_atan = $signed(w_atan_tab[r_iter]);
        w_x_sh = r_x >>> r_iter;
        w_y_sh = r_y >>> r_iter;
        if (!r_z[W-1]) begin
            w_x_next = r_x - w_y_sh;
            w_y_next = r_y + w_x_sh;
            w_z_next = r_z - w_atan;
        end else begin
            w_x_next = r_x + w_y_sh;
            w_y_next = r_y - w_x_sh;
            w_z_next = r_z + w_atan;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (in_valid)  w_state_next = c_st_conv;
            c_st_conv: w_state_next = w_conv_err ? c_st_done : c_st_rot;
            c_st_rot:  if (r_iter == c_last_iter) w_state_next = c_st_done;
            c_st_done: if (out_ready) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_done);
    end

    // Result registers only load on the transition into DONE and hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_angle <= '0;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_theta <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid)
                        r_angle <= in_angle;
                end
                c_st_conv: begin
                    r_iter <= '0;
                    r_x    <= c_kinv;
                    r_y    <= '0;
                    r_z    <= w_z0;
                    if (w_conv_err) begin
                        r_cos   <= '0;
                        r_sin   <= '0;
                        r_theta <= '0;
                        r_err   <= 1'b1;
                    end
                end
                c_st_rot: begin
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    r_z <= w_z_next;
                    if (r_iter == c_last_iter) begin
                        r_iter  <= '0;
                        r_cos   <= w_x_next;
                        r_sin   <= w_y_next;
                        r_theta <= w_z_next;
                        r_err   <= 1'b0;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_cos   = r_cos;
    assign out_sin   = r_sin;
    assign out_theta = r_theta;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cordic_cos_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cordic_cos_iter: directed bench, ITER=16 and ITER=24 instances in step   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_cordic_cos_iter;

    localparam int W      = 32;
    localparam int FRAC   = 30;
    localparam int ITER_A = 16;
    localparam int ITER_B = 24;
    localparam longint TOL_A = longint'(1) << (FRAC - ITER_A + 2);
    localparam longint TOL_B = longint'(1) << (FRAC - ITER_B + 2);

    // round(f(angle) * 2^30)
    localparam longint ONE   = 1073741824;
    localparam longint COS1  = 580145183;
    localparam longint SIN1  = 903522590;
    localparam longint COS15 = 75953492;
    localparam longint SIN15 = 1071052086;
    localparam longint COS05 = 942297101;
    localparam longint SIN05 = 514779252;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_angle;

    logic                in_ready_a, out_valid_a, out_err_a;
    logic signed [W-1:0] cos_a, sin_a, theta_a;
    logic                in_ready_b, out_valid_b, out_err_b;
    logic signed [W-1:0] cos_b, sin_b, theta_b;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_a;
    int lat_b;

    always #5 clk = ~clk;

    cordic_cos_iter #(.W(W), .FRAC(FRAC), .ITER(ITER_A)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_angle(in_angle), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_cos(cos_a), .out_sin(sin_a), .out_theta(theta_a), .out_err(out_err_a)
    );

    cordic_cos_iter #(.W(W), .FRAC(FRAC), .ITER(ITER_B)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_angle(in_angle), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_cos(cos_b), .out_sin(sin_b), .out_theta(theta_b), .out_err(out_err_b)
    );

    task automatic check_val(input string tag, input longint got, input longint exp,
                             input longint tol);
        longint diff;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        n_cmp++;
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Present one angle, then wait (bounded) until both instances show a result.
    task automatic run_op(input logic [31:0] ang);
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = ang;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_angle = '0;
        lat_a = 0;
        lat_b = 0;
        for (int n = 1; n <= 40; n++) begin
            if (lat_a == 0 && out_valid_a) lat_a = n;
            if (lat_b == 0 && out_valid_b) lat_b = n;
            if (lat_a != 0 && lat_b != 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("ready_after_take", longint'(in_ready_a), 1, 0);
        check_val("valid_after_take", longint'(out_valid_a), 0, 0);
    endtask

    task automatic check_ok(input string tag, input longint c, input longint s);
        check_val({tag, " lat_a"}, lat_a, ITER_A + 2, 0);
        check_val({tag, " lat_b"}, lat_b, ITER_B + 2, 0);
        check_val({tag, " err_a"}, longint'(out_err_a), 0, 0);
        check_val({tag, " err_b"}, longint'(out_err_b), 0, 0);
        check_val({tag, " cos_a"}, cos_a, c, TOL_A);
        check_val({tag, " sin_a"}, sin_a, s, TOL_A);
        check_val({tag, " theta_a"}, theta_a, 0, TOL_A);
        check_val({tag, " cos_b"}, cos_b, c, TOL_B);
        check_val({tag, " sin_b"}, sin_b, s, TOL_B);
        check_val({tag, " theta_b"}, theta_b, 0, TOL_B);
    endtask

    task automatic check_bad(input string tag);
        check_val({tag, " lat_a"}, lat_a, 2, 0);
        check_val({tag, " lat_b"}, lat_b, 2, 0);
        check_val({tag, " err_a"}, longint'(out_err_a), 1, 0);
        check_val({tag, " err_b"}, longint'(out_err_b), 1, 0);
        check_val({tag, " cos_a"}, cos_a, 0, 0);
        check_val({tag, " sin_a"}, sin_a, 0, 0);
        check_val({tag, " theta_a"}, theta_a, 0, 0);
        check_val({tag, " cos_b"}, cos_b, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_angle  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst in_ready", longint'(in_ready_a), 1, 0);
        check_val("rst out_valid", longint'(out_valid_a), 0, 0);
        check_val("rst cos", cos_a, 0, 0);
        check_val("rst sin", sin_a, 0, 0);
        check_val("rst theta", theta_a, 0, 0);
        check_val("rst err", longint'(out_err_a), 0, 0);
        check_val("rst in_ready_b", longint'(in_ready_b), 1, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(32'h0000_0000); check_ok("zero", ONE, 0);       consume();
        run_op(32'h3F80_0000); check_ok("p1", COS1, SIN1);     consume();
        run_op(32'hBF80_0000); check_ok("m1", COS1, -SIN1);    consume();
        run_op(32'h3FC0_0000); check_ok("p1.5", COS15, SIN15); consume();
        run_op(32'h4000_0000); check_bad("two");               consume();
        run_op(32'h7F80_0000); check_bad("inf");               consume();
        run_op(32'h3FCC_CCCD); check_bad("p1.6");              consume();

        // Backpressure: result must hold while new angles are offered.
        run_op(32'h3F80_0000); check_ok("bp", COS1, SIN1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_angle = 32'h4000_0000;
            @(posedge clk); #1;
            check_val("bp valid", longint'(out_valid_a), 1, 0);
            check_val("bp ready", longint'(in_ready_a), 0, 0);
            check_val("bp cos", cos_a, COS1, TOL_A);
            check_val("bp sin", sin_a, SIN1, TOL_A);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_angle = '0;
        consume();
        repeat (4) begin
            @(posedge clk); #1;
            check_val("idle no valid", longint'(out_valid_a), 0, 0);
        end
        check_val("idle hold cos", cos_a, COS1, TOL_A);
        check_val("idle hold err", longint'(out_err_a), 0, 0);

        // Reset during rotation 5 discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("mid iter", longint'(u_a.r_iter), 5, 0);
        reset_n = 1'b0;
        #1;
        check_val("mid rst cos", cos_a, 0, 0);
        check_val("mid rst sin", sin_a, 0, 0);
        check_val("mid rst theta", theta_a, 0, 0);
        check_val("mid rst valid", longint'(out_valid_a), 0, 0);
        check_val("mid rst ready", longint'(in_ready_a), 1, 0);
        check_val("mid rst cos_b", cos_b, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid_a || out_valid_b) seen++;
        end
        check_val("no result after rst", seen, 0, 0);

        run_op(32'h3F00_0000); check_ok("half", COS05, SIN05); consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
